core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the instruction/data memory handshakes and the instruction-register load, and generates the datapath selects, RegWrite for the decode stage's register file, and PC update. It also raises traps for illegal opcodes, ECALL/EBREAK and memory timeouts, and counts retired instructions.

---
 rtl/core_sequencer.sv | 159 +++++++++++++++
 tb/tb_core_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RV32I control FSM (fetch/decode/execute/memory/writeback) with traps and retire count
module core_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             mdr_load,
  output logic             alu_src_imm,
  output logic             alu_a_pc,
  output logic [1:0]       wb_sel,
  output logic             RegWrite,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
  } state_e;
  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE,
    C_OPIMM, C_OP, C_FENCE, C_SYSTEM, C_ILLEGAL
  } cls_e;
  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, cls_dec;
  logic             br_q, br_d;
  logic [1:0]       cause_q, cause_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             timeout;

  // Opcode classification; anything outside the RV32I base set is illegal.
  always_comb begin
    case (opcode)
      7'b0110111: cls_dec = C_LUI;
      7'b0010111: cls_dec = C_AUIPC;
      7'b1101111: cls_dec = C_JAL;
      7'b1100111: cls_dec = C_JALR;
      7'b1100011: cls_dec = C_BRANCH;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b0010011: cls_dec = C_OPIMM;
      7'b0110011: cls_dec = C_OP;
      7'b0001111: cls_dec = C_FENCE;
      7'b1110011: cls_dec = C_SYSTEM;
      default:    cls_dec = C_ILLEGAL;
    endcase
  end

  // Timeout fires on the MEM_TIMEOUT-th consecutive ack-less cycle; an ack in that cycle wins.
  assign timeout = (MEM_TIMEOUT != 0) && (wait_q == WW'(MEM_TIMEOUT - 1));

  // Next-state, datapath selects and strobes; everything defaults to 0 / hold.
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    br_d        = br_q;
    cause_d     = cause_q;
    wait_d      = '0;
    ret_d       = ret_q;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    mdr_load    = 1'b0;
    alu_src_imm = 1'b0;
    alu_a_pc    = 1'b0;
    wb_sel      = 2'b00;
    RegWrite    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = 2'b00;
    case (state_q)
      S_IDLE: state_d = run_en ? S_FETCH : S_IDLE;
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
        if (imem_ack) state_d = S_DECODE;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end else wait_d = wait_q + 1'b1;
      end
      S_DECODE: begin
        cls_d   = cls_dec;
        state_d = (cls_dec == C_ILLEGAL) ? S_TRAP : S_EXECUTE;
        cause_d = (cls_dec == C_ILLEGAL) ? 2'b01 : cause_q;
      end
      S_EXECUTE: begin
        alu_src_imm = cls_q inside {C_OPIMM, C_LOAD, C_STORE, C_JALR, C_AUIPC};
        alu_a_pc    = cls_q == C_AUIPC;
        br_d        = branch_taken;
        if (cls_q == C_SYSTEM && func3 == 3'b000) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else state_d = (cls_q inside {C_LOAD, C_STORE}) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = cls_q == C_STORE;
        mdr_load = cls_q == C_LOAD && dmem_ack;
        if (dmem_ack) state_d = S_WRITEBACK;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end else wait_d = wait_q + 1'b1;
      end
      S_WRITEBACK: begin
        pc_write = 1'b1;
        pc_sel   = (cls_q == C_JAL || (cls_q == C_BRANCH && br_q)) ? 2'b01 :
                   (cls_q == C_JALR) ? 2'b10 : 2'b00;
        RegWrite = cls_q inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OPIMM, C_OP};
        wb_sel   = (cls_q == C_LUI) ? 2'b11 :
                   (cls_q inside {C_JAL, C_JALR}) ? 2'b10 :
                   (cls_q == C_LOAD) ? 2'b01 : 2'b00;
        ret_d    = ret_q + 1'b1;
        state_d  = run_en ? S_FETCH : S_IDLE;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // State and bookkeeping registers; reset drops any outstanding request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_FENCE;
      br_q    <= 1'b0;
      cause_q <= 2'b00;
      wait_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      br_q    <= br_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
    end
  end

  assign trap       = state_q == S_TRAP;
  assign trap_cause = cause_q;
  assign retired    = ret_q;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: randomized and directed instruction streams checked against a phase-level model
module tb_core_sequencer;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011, OPI = 7'b0010011;
  localparam logic [6:0] OP = 7'b0110011, FEN = 7'b0001111, SYS = 7'b1110011;

  typedef struct packed {
    logic ireq, ild, dreq, dwe, mdr, src, apc;
    logic [1:0] wb;
    logic rw, pw;
    logic [1:0] ps;
    logic tr;
    logic [1:0] tc;
  } ov_t;

  logic clk = 1'b0, rst_n = 1'b1, run_en = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic branch_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic imem_req, ir_load, dmem_req, dmem_we, mdr_load, alu_src_imm, alu_a_pc;
  logic RegWrite, pc_write, trap;
  logic [1:0] wb_sel, pc_sel, trap_cause;
  logic [3:0] retired;
  ov_t obs;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] exp_ret = '0;
  logic [6:0] ops [11] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP, FEN, SYS};

  core_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .opcode(opcode), .func3(func3),
    .branch_taken(branch_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .mdr_load(mdr_load), .alu_src_imm(alu_src_imm), .alu_a_pc(alu_a_pc), .wb_sel(wb_sel),
    .RegWrite(RegWrite), .pc_write(pc_write), .pc_sel(pc_sel), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  assign obs = {imem_req, ir_load, dmem_req, dmem_we, mdr_load, alu_src_imm, alu_a_pc,
                wb_sel, RegWrite, pc_write, pc_sel, trap, trap_cause};

  always #5 clk = ~clk;

  function automatic logic legal(input logic [6:0] op);
    return op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP, FEN, SYS};
  endfunction
  function automatic logic uses_imm(input logic [6:0] op);
    return op inside {OPI, LD, ST, JALR, AUIPC};
  endfunction
  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {LUI, AUIPC, JAL, JALR, LD, OPI, OP};
  endfunction
  function automatic logic [1:0] wb_of(input logic [6:0] op);
    return op == LUI ? 2'b11 : (op == JAL || op == JALR) ? 2'b10 : op == LD ? 2'b01 : 2'b00;
  endfunction
  function automatic logic [1:0] pc_of(input logic [6:0] op, input logic br);
    return (op == JAL || (op == BR && br)) ? 2'b01 : op == JALR ? 2'b10 : 2'b00;
  endfunction

  task automatic chk(input string tag, input ov_t e);
    #1;
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s outputs got %h expected %h", tag, obs, e);
    end
    n_cmp++;
    assert (retired === exp_ret) else begin
      n_bad++;
      $error("FAIL %s retired got %0d expected %0d", tag, retired, exp_ret);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    imem_ack     = 1'($urandom);
    dmem_ack     = 1'($urandom);
    branch_taken = 1'($urandom);
    run_en       = 1'($urandom);
  endtask

  task automatic trap_hold(input logic [1:0] cause);
    ov_t e;
    for (int i = 0; i < 3; i++) begin
      noise();
      e = '0;
      e.tr = 1'b1;
      e.tc = cause;
      chk("trap", e);
    end
  endtask

  task automatic do_reset();
    noise();
    rst_n = 1'b0;
    exp_ret = '0;
    chk("reset", '0);
    chk("reset-hold", '0);
    noise();
    rst_n  = 1'b1;
    run_en = 1'b1;
    chk("idle-release", '0);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic br,
                           input int nf, input int nd, input logic cont);
    ov_t e;
    opcode = op;
    func3  = f3;
    for (int i = 0; i <= nf && i < 4; i++) begin
      noise();
      imem_ack = (i == nf);
      e = '0;
      e.ireq = 1'b1;
      e.ild  = imem_ack;
      chk("fetch", e);
    end
    if (nf > 3) begin
      trap_hold(2'b11);
      return;
    end
    noise();
    chk("decode", '0);
    if (!legal(op)) begin
      trap_hold(2'b01);
      return;
    end
    noise();
    branch_taken = br;
    e = '0;
    e.src = uses_imm(op);
    e.apc = op == AUIPC;
    chk("execute", e);
    if (op == SYS && f3 == 3'b000) begin
      trap_hold(2'b10);
      return;
    end
    if (op == LD || op == ST) begin
      for (int i = 0; i <= nd && i < 4; i++) begin
        noise();
        dmem_ack = (i == nd);
        e = '0;
        e.dreq = 1'b1;
        e.dwe  = op == ST;
        e.mdr  = op == LD && dmem_ack;
        chk("memory", e);
      end
      if (nd > 3) begin
        trap_hold(2'b11);
        return;
      end
    end
    noise();
    run_en = cont;
    branch_taken = ~br;
    e = '0;
    e.pw = 1'b1;
    e.ps = pc_of(op, br);
    e.rw = writes_rd(op);
    e.wb = wb_of(op);
    chk("writeback", e);
    exp_ret++;
    if (!cont) begin
      noise();
      run_en = 1'b0;
      chk("idle", '0);
      noise();
      run_en = 1'b1;
      chk("idle-go", '0);
    end
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    ov_t e;
    #2;
    do_reset();
    run_instr(OPI, 3'b000, 1'b0, 0, 0, 1'b1);
    run_instr(OPI, 3'b000, 1'b0, 3, 0, 1'b1);
    run_instr(LD,  3'b010, 1'b0, 0, 3, 1'b1);
    run_instr(ST,  3'b010, 1'b0, 1, 0, 1'b1);
    run_instr(BR,  3'b000, 1'b1, 0, 0, 1'b1);
    run_instr(BR,  3'b000, 1'b0, 0, 0, 1'b1);
    run_instr(JALR, 3'b000, 1'b1, 0, 0, 1'b1);
    run_instr(JAL, 3'b000, 1'b0, 2, 0, 1'b1);
    run_instr(LUI, 3'b000, 1'b1, 0, 0, 1'b1);
    run_instr(AUIPC, 3'b000, 1'b0, 0, 0, 1'b0);
    run_instr(FEN, 3'b000, 1'b1, 0, 0, 1'b1);
    run_instr(SYS, 3'b001, 1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 10)];
      f3 = (op == SYS) ? 3'($urandom_range(1, 7)) : 3'($urandom);
      run_instr(op, f3, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3) != 0);
    end
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b1);
    do_reset();
    run_instr(OP, 3'b000, 1'b0, 0, 0, 1'b1);
    run_instr(SYS, 3'b000, 1'b0, 0, 0, 1'b1);
    do_reset();
    run_instr(OPI, 3'b000, 1'b0, 9, 0, 1'b1);
    do_reset();
    run_instr(ST, 3'b010, 1'b0, 0, 9, 1'b1);
    do_reset();
    opcode = LD;
    func3  = 3'b010;
    noise();
    imem_ack = 1'b1;
    e = '0;
    e.ireq = 1'b1;
    e.ild  = 1'b1;
    chk("rst-fetch", e);
    noise();
    chk("rst-decode", '0);
    noise();
    e = '0;
    e.src = 1'b1;
    chk("rst-execute", e);
    noise();
    dmem_ack = 1'b0;
    e = '0;
    e.dreq = 1'b1;
    chk("rst-memory", e);
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
